// File: rtl/bsg_cgol_node_scheduler.sv
// bsg_cgol_node_scheduler
// Round-robin scheduler that shares one outbound channel among nodes_p
// requesters. The grant is locked for a whole packet, and priority rotates
// to the node after the owner once the packet's last beat is accepted.
// Per-node done levels are folded into a sticky all-done flag. That flag only
// rises once the channel is idle.
//
// Optional stall watchdog: define BSG_CGOL_SCHED_WATCHDOG_EN. When it is not
// defined, timeout_o is tied low and no counter exists.
//
// Handshake: a beat moves on a cycle where valid and ready are both high.
// On the node side, v_i is valid and yumi_o is the same-cycle accept.
// On the channel side, v_o is valid and ready_i is the accept.
// v_o never depends on ready_i.
module bsg_cgol_node_scheduler #(
   parameter int nodes_p   = 4,
   parameter int width_p   = 80,
   parameter int timeout_p = 1024,
   localparam int id_w_lp  = (nodes_p > 1) ? $clog2(nodes_p) : 1
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic [nodes_p-1:0]         v_i,
   input  logic [nodes_p*width_p-1:0] data_i,
   input  logic [nodes_p-1:0]         last_i,
   output logic [nodes_p-1:0]         yumi_o,
   output logic                       v_o,
   output logic [width_p-1:0]         data_o,
   output logic                       last_o,
   input  logic                       ready_i,
   input  logic [nodes_p-1:0]         done_i,
   output logic [id_w_lp-1:0]         grant_id_o,
   output logic                       all_done_o,
   output logic                       timeout_o,
   output logic [1:0]                 state_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   if (nodes_p < 1 || nodes_p > 16 || width_p < 1 || timeout_p < 1) begin : g_bad_params
      $error("bsg_cgol_node_scheduler: parameter out of range");
   end

   state_e               state_r;
   logic [id_w_lp-1:0]   ptr_r;
   logic [nodes_p-1:0]   done_seen_r;
   logic                 arb_found;
   logic [id_w_lp-1:0]   arb_idx;
   logic [id_w_lp-1:0]   ptr_next;
   logic                 xfer;

   assign state_o = state_r;
   assign xfer    = v_o & ready_i;

   // Priority rotates to the node after the one that just finished
   assign ptr_next = (grant_id_o == id_w_lp'(nodes_p - 1)) ? '0 : grant_id_o + 1'b1;

   // First requester at or above the pointer, wrapping modulo nodes_p
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      for (int i = 0; i < nodes_p; i++) begin
         if (!arb_found && v_i[(int'(ptr_r) + i) % nodes_p]) begin
            arb_found = 1'b1;
            arb_idx   = id_w_lp'((int'(ptr_r) + i) % nodes_p);
         end
      end
   end

   // Channel and accept signals pass straight through from the owner while BUSY
   always_comb begin
      v_o    = 1'b0;
      data_o = '0;
      last_o = 1'b0;
      yumi_o = '0;
      if (state_r == BUSY) begin
         v_o                = v_i[grant_id_o];
         data_o             = data_i[grant_id_o*width_p +: width_p];
         last_o             = last_i[grant_id_o];
         yumi_o[grant_id_o] = v_i[grant_id_o] & ready_i;
      end
   end

`ifdef BSG_CGOL_SCHED_WATCHDOG_EN
   localparam int stall_w_lp = $clog2(timeout_p + 1);
   logic [stall_w_lp-1:0] stall_cnt_r;
   logic                  stall_trip;

   // The packet is forcibly ended on the stall cycle that brings the count to timeout_p
   assign stall_trip = (state_r == BUSY) && !xfer
                       && (stall_cnt_r == stall_w_lp'(timeout_p - 1));

   // Count consecutive BUSY cycles with no beat; saturates at timeout_p
   always_ff @(posedge clk_i) begin
      if (reset_i || state_r != BUSY || xfer)
         stall_cnt_r <= '0;
      else if (stall_cnt_r != stall_w_lp'(timeout_p))
         stall_cnt_r <= stall_cnt_r + 1'b1;
   end
`else
   assign timeout_o = 1'b0;
`endif

   // Control FSM: arbitrate in IDLE, hold the grant through a packet, park in DONE
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r     <= IDLE;
         ptr_r       <= '0;
         grant_id_o  <= '0;
         done_seen_r <= '0;
         all_done_o  <= 1'b0;
`ifdef BSG_CGOL_SCHED_WATCHDOG_EN
         timeout_o   <= 1'b0;
`endif
      end else begin
         done_seen_r <= done_seen_r | done_i;
         case (state_r)
            IDLE: begin
               if (arb_found) begin
                  grant_id_o <= arb_idx;
                  state_r    <= BUSY;
               end else if (&done_seen_r) begin
                  all_done_o <= 1'b1;
                  state_r    <= DONE;
               end
            end
            BUSY: begin
               if (xfer && last_o) begin
                  ptr_r   <= ptr_next;
                  state_r <= IDLE;
               end
`ifdef BSG_CGOL_SCHED_WATCHDOG_EN
               else if (stall_trip) begin
                  timeout_o <= 1'b1;
                  ptr_r     <= ptr_next;
                  state_r   <= IDLE;
               end
`endif
            end
            DONE: begin
               state_r <= DONE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule
